// File: rtl/egress_arbiter_pkg.sv
// Shared types for the egress arbiter slice: AXI-Stream-with-dest source and
// sink structs, the arbiter state enum and a saturating counter helper.
package egress_arbiter_pkg;

  localparam int AXIS_DATA_WIDTH = 8;
  localparam int AXIS_DEST_WIDTH = 4;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic                       tvalid;
    logic                       tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } egress_arb_state_t;

  // Saturating 16-bit increment for statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set bit of the eligible
// mask scanning upward from ptr+1 with wrap-around. Shared by other arbiters.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest eligible index after ptr overwrites last
  always_comb begin
    winner    = ptr;
    cand      = ptr;
    any_valid = |eligible;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (eligible[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// Egress port arbiter: shares one switch egress between NUM_REQ requesters,
// admitting only frames addressed to EGRESS_ID. Grants are round-robin and
// held until the frame's tlast handshake, or released after the winner has
// held tvalid low for too long. The data path is a pure combinational mux.
// Optional build macro EGRESS_ARBITER_STATS_EN adds per-requester frame
// counters and an abort counter.
module egress_arbiter
  import egress_arbiter_pkg::*;
#(
  parameter int                         NUM_REQ          = 4,
  parameter logic [AXIS_DEST_WIDTH-1:0] EGRESS_ID        = '0,
  parameter int                         IDLE_LIMIT_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  axis_d_source_t [NUM_REQ-1:0]     req_source,
  output axis_d_sink_t   [NUM_REQ-1:0]     req_sink,
  input  axis_d_sink_t                     egress_sink,
  output axis_d_source_t                   egress_source,
  output logic                             grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_idx,
  output logic                             abort_pulse
`ifdef EGRESS_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]         frame_cnt,
  output logic [15:0]                      abort_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Last idle count before release: the winner is dropped on the low cycle
  // that would bring the counter to its all-ones value.
  localparam logic [IDLE_LIMIT_WIDTH-1:0] IDLE_LAST =
    {{(IDLE_LIMIT_WIDTH-1){1'b1}}, 1'b0};

  egress_arb_state_t             state;
  egress_arb_state_t             next_state;
  logic [IDX_W-1:0]              ptr;
  logic [IDX_W-1:0]              winner;
  logic [IDLE_LIMIT_WIDTH-1:0]   idle_cnt;
  logic [NUM_REQ-1:0]            eligible;
  logic                          any_valid;
  axis_d_source_t                win_src;
  logic                          handshake;
  logic                          frame_done;
  logic                          timeout;

  // A requester competes only while it is valid and addressed to this port
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_source[i].tvalid && (req_source[i].tdest == EGRESS_ID);
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign win_src     = req_source[grant_idx];
  assign handshake   = (state == BUSY) && egress_sink.tready && win_src.tvalid;
  assign frame_done  = handshake && win_src.tlast;
  assign timeout     = (state == BUSY) && !win_src.tvalid && (idle_cnt == IDLE_LAST);
  assign grant_valid = (state == BUSY);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decision and the granted requester's data/ready mux
  always_comb begin
    next_state    = state;
    egress_source = '0;
    req_sink      = '0;
    case (state)
      IDLE: begin
        if (any_valid) next_state = BUSY;
      end
      BUSY: begin
        egress_source                = win_src;
        req_sink[grant_idx].tready   = egress_sink.tready;
        if (frame_done || timeout) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant bookkeeping: winner latch, rotation pointer, stall counter, abort pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_idx   <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      idle_cnt    <= '0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= timeout;
      if (state == IDLE) begin
        idle_cnt <= '0;
        if (any_valid) grant_idx <= winner;
      end else begin
        if (win_src.tvalid) idle_cnt <= '0;
        else                idle_cnt <= idle_cnt + IDLE_LIMIT_WIDTH'(1);
        if (frame_done || timeout) ptr <= grant_idx;
      end
    end
  end

`ifdef EGRESS_ARBITER_STATS_EN
  // Saturating per-requester completed-frame and abort statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (frame_done) frame_cnt[grant_idx] <= sat_inc16(frame_cnt[grant_idx]);
      if (timeout)    abort_cnt            <= sat_inc16(abort_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter. Requester queues drive AXIS beats,
// expected egress beats go into a scoreboard queue, and a negedge monitor
// pops and compares every accepted egress beat.
module tb_egress_arbiter;
  import egress_arbiter_pkg::*;

  localparam int                         NREQ      = 4;
  localparam logic [AXIS_DEST_WIDTH-1:0] EGRESS_ID = 4'h0;
  localparam logic [AXIS_DEST_WIDTH-1:0] OTHER_ID  = 4'h5;

  typedef struct {
    logic [7:0] data;
    logic [3:0] dest;
    logic       last;
  } beat_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                          clk;
  logic                          reset_n;
  axis_d_source_t [NREQ-1:0]     req_source;
  axis_d_sink_t   [NREQ-1:0]     req_sink;
  axis_d_sink_t                  egress_sink;
  axis_d_source_t                egress_source;
  logic                          grant_valid;
  logic [1:0]                    grant_idx;
  logic                          abort_pulse;
`ifdef EGRESS_ARBITER_STATS_EN
  logic [NREQ-1:0][15:0]         frame_cnt;
  logic [15:0]                   abort_cnt;
`endif

  beat_t       src_q [NREQ][$];
  exp_t        exp_q [$];
  logic        rdy_q [$];
  logic [NREQ-1:0] accept_pending;
  int          pass_cnt;
  int          total_cnt;
  exp_t        mon_e;
  logic        hold_pending;
  logic [7:0]  hold_data;
  logic        bubble_pending;

  egress_arbiter #(
    .NUM_REQ          (NREQ),
    .EGRESS_ID        (EGRESS_ID),
    .IDLE_LIMIT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_source    (req_source),
    .req_sink      (req_sink),
    .egress_sink   (egress_sink),
    .egress_source (egress_source),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .abort_pulse   (abort_pulse)
`ifdef EGRESS_ARBITER_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .abort_cnt     (abort_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Queue one frame on requester r; optionally record the beats it should produce on egress
  task automatic applyStimulus(input int r, input logic [7:0] base, input int n,
                               input logic [3:0] dest, input bit expect_it,
                               input bit with_last);
    beat_t bt;
    exp_t  ex;
    for (int b = 0; b < n; b++) begin
      bt.data = base + 8'(b);
      bt.dest = dest;
      bt.last = with_last && (b == n - 1);
      src_q[r].push_back(bt);
      if (expect_it) begin
        ex.idx  = 2'(r);
        ex.data = bt.data;
        ex.last = bt.last;
        exp_q.push_back(ex);
      end
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0);
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!all_empty()) checkOutput("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Requester and downstream driver: updates just after each rising edge
  initial begin
    req_source         = '0;
    egress_sink.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (accept_pending[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_source[i].tvalid = 1'b1;
          req_source[i].tdata  = src_q[i][0].data;
          req_source[i].tdest  = src_q[i][0].dest;
          req_source[i].tlast  = src_q[i][0].last;
        end else begin
          req_source[i] = '0;
        end
      end
      if (rdy_q.size() > 0) egress_sink.tready = rdy_q.pop_front();
      else                  egress_sink.tready = 1'b1;
    end
  end

  // Monitor: on each falling edge compare accepted egress beats with the scoreboard
  initial begin
    accept_pending = '0;
    hold_pending   = 1'b0;
    bubble_pending = 1'b0;
    hold_data      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        accept_pending[i] = req_source[i].tvalid && req_sink[i].tready;
      if (!reset_n) begin
        hold_pending   = 1'b0;
        bubble_pending = 1'b0;
      end else begin
        if (bubble_pending) begin
          checkOutput("bubble_grant_valid", grant_valid, 1'b0);
          bubble_pending = 1'b0;
        end
        if (hold_pending) begin
          checkOutput("hold_tvalid", egress_source.tvalid, 1'b1);
          checkOutput("hold_tdata", egress_source.tdata, hold_data);
          hold_pending = 1'b0;
        end
        if (req_source[3].tvalid && req_source[3].tdest != EGRESS_ID)
          checkOutput("filter_ready3", req_sink[3].tready, 1'b0);
        if (egress_source.tvalid && egress_sink.tready) begin
          if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_beat", {grant_idx, egress_source.tdata}, 32'hFFFF);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_beat", {grant_idx, egress_source.tdata, egress_source.tlast},
                        {mon_e.idx, mon_e.data, mon_e.last});
            if (egress_source.tlast) bubble_pending = 1'b1;
          end
        end else if (egress_source.tvalid) begin
          hold_pending = 1'b1;
          hold_data    = egress_source.tdata;
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    int n;
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    #2;
    checkOutput("rst_grant_valid", grant_valid, 1'b0);
    checkOutput("rst_grant_idx", grant_idx, 2'd0);
    checkOutput("rst_abort", abort_pulse, 1'b0);
    checkOutput("rst_tready", req_sink, 4'h0);
    checkOutput("rst_egress", egress_source, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single requester, one-cycle grant latency
    @(posedge clk); #2;
    applyStimulus(1, 8'hA0, 4, EGRESS_ID, 1'b1, 1'b1);
    @(posedge clk); #2;
    checkOutput("t1_tvalid", req_source[1].tvalid, 1'b1);
    checkOutput("t1_ready_not_yet", req_sink[1].tready, 1'b0);
    @(posedge clk); #2;
    checkOutput("t1_ready", req_sink[1].tready, 1'b1);
    checkOutput("t1_grant_idx", grant_idx, 2'd1);
    checkOutput("t1_grant_valid", grant_valid, 1'b1);
    wait_drain(100);

    // Round robin from reset: expected order 0,1,2,3,0
    pulse_reset();
    applyStimulus(0, 8'h10, 2, EGRESS_ID, 1'b1, 1'b1);
    applyStimulus(1, 8'h20, 2, EGRESS_ID, 1'b1, 1'b1);
    applyStimulus(2, 8'h30, 2, EGRESS_ID, 1'b1, 1'b1);
    applyStimulus(3, 8'h40, 2, EGRESS_ID, 1'b1, 1'b1);
    applyStimulus(0, 8'h14, 2, EGRESS_ID, 1'b1, 1'b1);
    wait_drain(200);

    // Lock: req0 arrives while req2 holds the grant
    applyStimulus(2, 8'h50, 4, EGRESS_ID, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    applyStimulus(0, 8'h60, 2, EGRESS_ID, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("lock_grant_idx", grant_idx, 2'd2);
    checkOutput("lock_req0_ready", req_sink[0].tready, 1'b0);
    checkOutput("lock_req2_ready", req_sink[2].tready, 1'b1);
    wait_drain(100);

    // Backpressure during a frame
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    applyStimulus(3, 8'h70, 4, EGRESS_ID, 1'b1, 1'b1);
    wait_drain(100);

    // Abort: req1 sends two beats with no tlast and goes silent
    applyStimulus(1, 8'h80, 2, EGRESS_ID, 1'b1, 1'b0);
    n = 0;
    while (src_q[1].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_stall_reached", (src_q[1].size() == 0), 1'b1);
    applyStimulus(2, 8'h90, 2, EGRESS_ID, 1'b1, 1'b1);
    repeat (14) @(negedge clk);
    checkOutput("abort_not_yet", abort_pulse, 1'b0);
    checkOutput("abort_still_granted", grant_valid, 1'b1);
    @(negedge clk);
    checkOutput("abort_pulse", abort_pulse, 1'b1);
    checkOutput("abort_released", grant_valid, 1'b0);
    @(negedge clk);
    checkOutput("abort_pulse_one_cycle", abort_pulse, 1'b0);
    checkOutput("abort_next_granted", grant_valid, 1'b1);
    checkOutput("abort_next_idx", grant_idx, 2'd2);
    wait_drain(100);

    // Filtering plus asynchronous reset mid-frame on req0
    applyStimulus(3, 8'hE0, 2, OTHER_ID, 1'b0, 1'b1);
    applyStimulus(0, 8'hB0, 8, EGRESS_ID, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_egress_tvalid", egress_source.tvalid, 1'b0);
    checkOutput("async_rst_req0_ready", req_sink[0].tready, 1'b0);
    checkOutput("async_rst_grant_valid", grant_valid, 1'b0);
    checkOutput("async_rst_grant_idx", grant_idx, 2'd0);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    rdy_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    checkOutput("post_rst_idle", grant_valid, 1'b0);
    applyStimulus(0, 8'hD0, 2, EGRESS_ID, 1'b1, 1'b1);
    applyStimulus(3, 8'hC0, 2, EGRESS_ID, 1'b1, 1'b1);
    wait_drain(100);

    checkOutput("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
